mem_vector_collector: RTL and testbench
=======================================

# mem_vector_collector

Parametrised memory-return collector: it gathers LANES consecutive DATA_W-bit words from the data-memory read port into one vector register and tags the result with the destination register index. It sits between data memory and the vector register-file write-back stage. It generalises the fixed 16×16-bit output manager with configurable geometry, valid/ready handshakes on both sides and back-to-back load support.

## Interface
Parameters:
- DATA_W, 16, width of one memory word / lane
- LANES, 16, words per vector (≥2)
- RD_W, 5, destination register index width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a new vector load; sampled only when the collector can accept it
- RD_in  in  RD_W  destination register, latched on accepted start
- in_valid  in  1  memory word present on input_data
- input_data  in  DATA_W  memory word
- in_ready  out  1  collector accepts a word this cycle
- out_valid  out  1  complete vector available
- out_ready  in  1  write-back consumes vector
- RD_out  out  RD_W  latched destination register
- output_data  out  LANES×DATA_W  packed vector, lane 0 in the low DATA_W bits
- busy  out  1  state ≠ IDLE
- beat_cnt  out  $clog2(LANES)+1  words accepted in current load

## Operation
- FSM states: IDLE, COLLECT, HOLD.
- IDLE: start=1 → latch RD_in, clear beat_cnt, go COLLECT.
- COLLECT: in_ready=1. On in_valid && in_ready, write input_data to lane beat_cnt and increment beat_cnt. When the accepted word is lane LANES-1 → HOLD. start is ignored in COLLECT.
- HOLD: out_valid=1, in_ready=0. On out_ready → IDLE. If start=1 in the same cycle as out_ready, go straight to COLLECT, latch the new RD_in and clear beat_cnt (back-to-back loads, no idle bubble).
- Lanes not yet written in a load keep their previous contents. output_data is defined only while out_valid=1.
- RD_out and output_data stay stable for the whole of HOLD.
- beat_cnt saturates at LANES and is held in HOLD. It clears only on an accepted start.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, in_ready=0, out_valid=0, busy=0, beat_cnt=0, RD_out=0, all lanes=0. Reset applied mid-load discards the partial vector immediately.
- in_ready is a Moore output, high from the cycle after start is accepted.
- Latency from the final accepted beat to out_valid: 1 cycle. Minimum load time is LANES+1 cycles from start to out_valid with in_valid held high.
- A word whose in_valid is low is not consumed. Stalls of any length are allowed.
- output_data of lane k is updated at the clock edge where beat k is accepted.

## Configuration
- MEM_COLLECT_ABORT_EN defined: adds input port abort (1 bit). abort=1 in COLLECT or HOLD returns the FSM to IDLE on the next edge. out_valid and in_ready drop on that edge and beat_cnt clears. abort has priority over a word accepted or out_ready in the same cycle. Lane contents are left unchanged.
- MEM_COLLECT_ABORT_EN undefined: no abort port. A load can end only by completing, or by reset.

## Test plan
- Reset: drive rst=0 mid-COLLECT after 5 beats → outputs go to 0 immediately, state IDLE, beat_cnt=0.
- Basic load: start with RD_in=5'b00010, then words 0x0001..0x0010 on consecutive cycles → out_valid one cycle after the last beat, RD_out=2, lane k=k+1.
- Stalls: same load with in_valid deasserted every other cycle → identical vector, out_valid after 31 cycles. Words presented while in_valid=0 are not stored.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → out_valid, RD_out and output_data stable, in_ready=0. Pulse out_ready → IDLE.
- Back-to-back: out_ready=1 and start=1 (RD_in=7) in the same HOLD cycle → COLLECT next cycle, RD_out=7, beat_cnt=0. The second vector 0x0100..0x010F is collected correctly.
- With MEM_COLLECT_ABORT_EN: abort after 8 beats → IDLE next cycle, no out_valid. A following full load produces the correct vector.

Source files
------------

// File: rtl/mem_vector_collector_if.sv
// Bus bundle for mem_vector_collector: memory-side word stream with a
// start/RD_in command, and the vector-side valid/ready write-back port.
// master = the surrounding core (issues loads, feeds words, consumes vectors)
// slave  = the collector itself
interface mem_vector_collector_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int RD_W   = 5
);
  logic                     start;
  logic [RD_W-1:0]          RD_in;
  logic                     in_valid;
  logic [DATA_W-1:0]        input_data;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [RD_W-1:0]          RD_out;
  logic [LANES*DATA_W-1:0]  output_data;

  modport master (
    output start, RD_in, in_valid, input_data, out_ready,
    input  in_ready, out_valid, RD_out, output_data
  );

  modport slave (
    input  start, RD_in, in_valid, input_data, out_ready,
    output in_ready, out_valid, RD_out, output_data
  );
endinterface

// File: rtl/mem_vector_collector.sv
// mem_vector_collector: gathers LANES consecutive DATA_W-bit memory words
// into one packed vector and tags it with a destination register index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/in_ready move one word per transfer; out_valid/out_ready
// hand the complete vector to write-back. out_valid is held, with RD_out and
// output_data stable, until out_ready is seen. in_ready and out_valid are
// decoded from the state register only.
//
// Optional feature: define MEM_COLLECT_ABORT_EN to add an abort input that
// cancels a load in COLLECT or HOLD and returns to IDLE.
module mem_vector_collector #(
  parameter  int DATA_W = 16,
  parameter  int LANES  = 16,
  parameter  int RD_W   = 5,
  localparam int CNT_W  = $clog2(LANES) + 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MEM_COLLECT_ABORT_EN
  input  logic             abort,
`endif
  mem_vector_collector_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LANES - 1);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                beat_q, beat_d;
  logic [RD_W-1:0]                 rd_q, rd_d;
  logic [LANES-1:0][DATA_W-1:0]    lanes_q, lanes_d;
  logic                            accept;

  // Next state, beat counter, destination latch and lane writes.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rd_d    = rd_q;
    lanes_d = lanes_q;
    accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_COLLECT;
          rd_d    = bus.RD_in;
          beat_d  = '0;
        end
      end
      S_COLLECT: begin
        // in_ready is high for the whole of COLLECT, so in_valid alone
        // decides the transfer.
        if (bus.in_valid) begin
          accept = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          if (bus.start) begin
            // Back-to-back load: no idle bubble between vectors.
            state_d = S_COLLECT;
            rd_d    = bus.RD_in;
            beat_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MEM_COLLECT_ABORT_EN
    // Abort wins over a word or a vector handshake in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      beat_d  = '0;
      rd_d    = rd_q;
      accept  = 1'b0;
    end
`endif

    // Lane k is written only by beat k; other lanes keep old contents.
    for (int k = 0; k < LANES; k++) begin
      if (accept && (beat_q == CNT_W'(k))) begin
        lanes_d[k] = bus.input_data;
      end
    end
  end

  // State, counter, tag and lane registers; reset discards a partial load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      rd_q    <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rd_q    <= rd_d;
      lanes_q <= lanes_d;
    end
  end

  assign bus.in_ready    = (state_q == S_COLLECT);
  assign bus.out_valid   = (state_q == S_HOLD);
  assign bus.RD_out      = rd_q;
  assign bus.output_data = lanes_q;
  assign busy            = (state_q != S_IDLE);
  assign beat_cnt        = beat_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mem_vector_collector.sv
// Self-checking bench for mem_vector_collector. Expected {RD, vector} items
// are queued as words are driven and compared when write-back takes them.
module tb_mem_vector_collector;

  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int RD_W   = 5;
  localparam int CNT_W  = $clog2(LANES) + 1;
  localparam int W      = RD_W + LANES * DATA_W;

  logic             clk;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       state_dbg;
`ifdef MEM_COLLECT_ABORT_EN
  logic             abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item;

  mem_vector_collector_if #(.DATA_W(DATA_W), .LANES(LANES), .RD_W(RD_W)) bus ();

  mem_vector_collector #(.DATA_W(DATA_W), .LANES(LANES), .RD_W(RD_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MEM_COLLECT_ABORT_EN
    .abort     (abort),
`endif
    .bus       (bus),
    .busy      (busy),
    .beat_cnt  (beat_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare each vector taken by write-back with the queue head.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got rd=%0d with no expected vector", bus.RD_out);
      end else begin
        exp_item = exp_q.pop_front();
        if ({bus.RD_out, bus.output_data} !== exp_item) begin
          n_fail++;
          $display("FAIL sb_vector: got %h exp %h", {bus.RD_out, bus.output_data}, exp_item);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [RD_W-1:0] rd);
    bus.start = 1'b1;
    bus.RD_in = rd;
    step();
    bus.start = 1'b0;
    bus.RD_in = RD_W'($urandom);
  endtask

  // mode 0: base+k every cycle; 1: base+k, in_valid on alternate cycles;
  // 2: random words with random in_valid. edges = clock edges after the
  // start edge up to and including the final accepted beat.
  task automatic feed_beats(input logic [RD_W-1:0] rd, input int mode,
                            input logic [DATA_W-1:0] base, output int edges);
    logic [LANES*DATA_W-1:0] vec;
    logic [DATA_W-1:0]       w;
    logic                    acc;
    int                      beat;
    vec   = '0;
    beat  = 0;
    edges = 0;
    while (beat < LANES && edges < 400) begin
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (edges % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      w = (mode == 2) ? DATA_W'($urandom) : base + DATA_W'(beat);
      bus.input_data = bus.in_valid ? w : DATA_W'($urandom);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      step();
      edges++;
      if (acc) begin
        vec[beat*DATA_W +: DATA_W] = w;
        beat++;
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (beat != LANES) begin
      n_fail++;
      $display("FAIL feed_timeout: got %0d beats exp %0d", beat, LANES);
    end
    exp_q.push_back({rd, vec});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_timeout: out_valid got %b exp 1", bus.out_valid);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Values while reset is held from time zero.
    #2;
    n_checks++;
    if ({busy, bus.in_ready, bus.out_valid, beat_cnt, bus.RD_out, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got busy=%b rdy=%b ov=%b cnt=%0d rd=%0d st=%0d exp all 0",
               busy, bus.in_ready, bus.out_valid, beat_cnt, bus.RD_out, state_dbg);
    end
    n_checks++;
    if (bus.output_data !== '0) begin
      n_fail++;
      $display("FAIL reset_init_data: got %h exp 0", bus.output_data);
    end
    step();
    rst = 1'b1;
    step();
    // Partial load then asynchronous reset.
    start_load(5'd9);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid   = 1'b1;
      bus.input_data = 16'hA000 + 16'(k);
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (beat_cnt !== CNT_W'(5) || state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_pre: got cnt=%0d st=%0d exp cnt=5 st=1", beat_cnt, state_dbg);
    end
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, bus.in_ready, bus.out_valid, beat_cnt, bus.RD_out, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b rdy=%b ov=%b cnt=%0d rd=%0d st=%0d exp all 0",
               busy, bus.in_ready, bus.out_valid, beat_cnt, bus.RD_out, state_dbg);
    end
    n_checks++;
    if (bus.output_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_data: got %h exp 0", bus.output_data);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int edges;
    logic [LANES*DATA_W-1:0] vec;
    for (int k = 0; k < LANES; k++) vec[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
    start_load(5'b00010);
    n_checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b1 || beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL basic_start: got rdy=%b busy=%b cnt=%0d exp 1 1 0", bus.in_ready, busy, beat_cnt);
    end
    feed_beats(5'b00010, 0, 16'h0001, edges);
    n_checks++;
    if (edges != LANES || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got edges=%0d ov=%b exp edges=%0d ov=1", edges, bus.out_valid, LANES);
    end
    n_checks++;
    if (bus.RD_out !== 5'd2 || bus.output_data !== vec) begin
      n_fail++;
      $display("FAIL basic_vector: got rd=%0d data=%h exp rd=2 data=%h", bus.RD_out, bus.output_data, vec);
    end
    n_checks++;
    if (beat_cnt !== CNT_W'(LANES) || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got cnt=%0d rdy=%b exp cnt=%0d rdy=0", beat_cnt, bus.in_ready, LANES);
    end
    drain();
    n_checks++;
    if (state_dbg !== 2'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got st=%0d ov=%b exp st=0 ov=0", state_dbg, bus.out_valid);
    end
  endtask

  task automatic test_stalls();
    int edges;
    start_load(5'b00010);
    feed_beats(5'b00010, 1, 16'h0001, edges);
    n_checks++;
    if (edges != 31 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stalls_latency: got edges=%0d ov=%b exp edges=31 ov=1", edges, bus.out_valid);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int edges;
    logic [W-1:0] exp_local;
    start_load(5'd12);
    feed_beats(5'd12, 2, 16'h0000, edges);
    exp_local = exp_q[exp_q.size()-1];
    for (int c = 0; c < 10; c++) begin
      // A start offered while write-back stalls must not disturb HOLD.
      bus.start = (c == 4);
      bus.RD_in = 5'd30;
      step();
      bus.start = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.RD_out, bus.output_data} !== exp_local) begin
        n_fail++;
        $display("FAIL backpressure_c%0d: got ov=%b rdy=%b rd=%0d exp ov=1 rdy=0 rd=%0d",
                 c, bus.out_valid, bus.in_ready, bus.RD_out, exp_local[W-1 -: RD_W]);
      end
    end
    drain();
    n_checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_idle: got busy=%b ov=%b exp 0 0", busy, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    start_load(5'd3);
    feed_beats(5'd3, 0, 16'h0200, edges);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.RD_in     = 5'd7;
    step();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    n_checks++;
    if (state_dbg !== 2'd1 || bus.RD_out !== 5'd7 || beat_cnt !== '0 ||
        bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: got st=%0d rd=%0d cnt=%0d rdy=%b ov=%b exp 1 7 0 1 0",
               state_dbg, bus.RD_out, beat_cnt, bus.in_ready, bus.out_valid);
    end
    feed_beats(5'd7, 0, 16'h0100, edges);
    n_checks++;
    if (edges != LANES) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d exp %0d", edges, LANES);
    end
    drain();
  endtask

  task automatic test_random();
    int edges;
    logic [RD_W-1:0] rd;
    for (int i = 0; i < 4; i++) begin
      rd = RD_W'($urandom);
      start_load(rd);
      feed_beats(rd, 2, 16'h0000, edges);
      repeat ($urandom_range(0, 5)) step();
      drain();
    end
  endtask

`ifdef MEM_COLLECT_ABORT_EN
  task automatic test_abort();
    int edges;
    start_load(5'd6);
    for (int k = 0; k < 8; k++) begin
      bus.in_valid   = 1'b1;
      bus.input_data = 16'hB000 + 16'(k);
      step();
    end
    // Word offered alongside abort must be dropped.
    abort = 1'b1;
    step();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (state_dbg !== 2'd0 || beat_cnt !== '0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_collect: got st=%0d cnt=%0d rdy=%b ov=%b exp 0 0 0 0",
               state_dbg, beat_cnt, bus.in_ready, bus.out_valid);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet_c%0d: got ov=%b exp 0", c, bus.out_valid);
      end
    end
    // Abort while holding a finished vector: it is never handed over.
    start_load(5'd8);
    feed_beats(5'd8, 0, 16'h0300, edges);
    void'(exp_q.pop_back());
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (state_dbg !== 2'd0 || bus.out_valid !== 1'b0 || beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL abort_hold: got st=%0d ov=%b cnt=%0d exp 0 0 0", state_dbg, bus.out_valid, beat_cnt);
    end
    start_load(5'd11);
    feed_beats(5'd11, 0, 16'h0400, edges);
    drain();
  endtask
`endif

  // Test sequence and summary.
  initial begin
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.RD_in      = '0;
    bus.in_valid   = 1'b0;
    bus.input_data = '0;
    bus.out_ready  = 1'b0;
`ifdef MEM_COLLECT_ABORT_EN
    abort          = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stalls();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef MEM_COLLECT_ABORT_EN
    test_abort();
`endif
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d queued vectors exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
